// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: NUM_PORTS channels of WIDTH bits with output,
// direction, synchronised input, sticky masked edge capture and one irq line.
module mmio_gpio_bank #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h800
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  wdata,
  input  logic                         we,
  input  logic                         re,
  output logic                         sel,
  output logic [31:0]                  rdata,
  input  logic [NUM_PORTS*WIDTH-1:0]   pin_in,
  output logic [NUM_PORTS*WIDTH-1:0]   pin_out,
  output logic [NUM_PORTS*WIDTH-1:0]   pin_oe,
  output logic                         irq
);

  localparam int unsigned TOTAL     = NUM_PORTS * WIDTH;
  localparam logic [31:0] WIN_BYTES = 32'(NUM_PORTS * 32);

  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_IN     = 3'd1;
  localparam logic [2:0] REG_DIR    = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_MASK   = 3'd4;
  localparam logic [2:0] REG_POL    = 3'd5;

  logic [TOTAL-1:0] r_out;
  logic [TOTAL-1:0] r_dir;
  logic [TOTAL-1:0] r_status;
  logic [TOTAL-1:0] r_mask;
  logic [TOTAL-1:0] r_pol;
  logic [TOTAL-1:0] r_s1;
  logic [TOTAL-1:0] r_s2;
  logic [TOTAL-1:0] r_prev;
  logic [1:0]       r_warm;
  logic             r_irq;

  logic [31:0]      w_off;
  logic [2:0]       w_ch;
  logic [2:0]       w_reg;
  logic             w_wr;
  logic [TOTAL-1:0] w_clr;
  logic [TOTAL-1:0] w_evt;
  logic             w_unused;

  // Address decode: window hit, channel index and register offset
  assign w_off = addr - BASE_ADDR;
  assign w_ch  = w_off[7:5];
  assign w_reg = addr[4:2];
  assign sel   = (addr >= BASE_ADDR) && (w_off < WIN_BYTES);
  assign w_wr  = we && sel;

  // Load strobe carries no side effects; byte lane bits are ignored
  assign w_unused = ^{re, w_off, wdata};

  assign pin_out = r_out;
  assign pin_oe  = r_dir;
  assign irq     = r_irq;

  // Write-1-to-clear mask for STATUS of the addressed channel
  always_comb begin
    w_clr = '0;
    if (w_wr && (w_reg == REG_STATUS)) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        if (w_ch == 3'(p)) begin
          w_clr[p*WIDTH +: WIDTH] = wdata[WIDTH-1:0];
        end
      end
    end
  end

  // Per-bit edge event, suppressed until the synchroniser has settled
  always_comb begin
    w_evt = '0;
    if (r_warm == 2'd3) begin
      w_evt = (r_pol & r_prev & ~r_s2) | (~r_pol & r_s2 & ~r_prev);
    end
  end

  // Software-writable configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out  <= '0;
      r_dir  <= '0;
      r_mask <= '0;
      r_pol  <= '0;
    end else if (w_wr) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        if (w_ch == 3'(p)) begin
          case (w_reg)
            REG_OUT:  r_out[p*WIDTH +: WIDTH]  <= wdata[WIDTH-1:0];
            REG_DIR:  r_dir[p*WIDTH +: WIDTH]  <= wdata[WIDTH-1:0];
            REG_MASK: r_mask[p*WIDTH +: WIDTH] <= wdata[WIDTH-1:0];
            REG_POL:  r_pol[p*WIDTH +: WIDTH]  <= wdata[WIDTH-1:0];
            default:  ;
          endcase
        end
      end
    end
  end

  // Input synchroniser, edge history, warm-up, sticky status and irq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_prev   <= '0;
      r_warm   <= 2'd0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_s1     <= pin_in;
      r_s2     <= r_s1;
      r_prev   <= r_s2;
      if (r_warm != 2'd3) begin
        r_warm <= r_warm + 2'd1;
      end
      r_status <= (r_status & ~w_clr) | w_evt;
      r_irq    <= |(r_status & r_mask);
    end
  end

  // Combinational, zero-extended read data for the processor load mux
  always_comb begin
    rdata = '0;
    if (sel) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        if (w_ch == 3'(p)) begin
          case (w_reg)
            REG_OUT:    rdata = 32'(r_out[p*WIDTH +: WIDTH]);
            REG_IN:     rdata = 32'(r_s2[p*WIDTH +: WIDTH]);
            REG_DIR:    rdata = 32'(r_dir[p*WIDTH +: WIDTH]);
            REG_STATUS: rdata = 32'(r_status[p*WIDTH +: WIDTH]);
            REG_MASK:   rdata = 32'(r_mask[p*WIDTH +: WIDTH]);
            REG_POL:    rdata = 32'(r_pol[p*WIDTH +: WIDTH]);
            default:    rdata = '0;
          endcase
        end
      end
    end
  end

endmodule
